// File: rtl/operation_result_buffer.sv
// Small result FIFO behind the AND/OR/XOR operation stage. Each entry captures the
// selected result, its population count and the op code at write time.
module operation_result_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         ab_and,
  input  logic [WIDTH-1:0]         ab_or,
  input  logic [WIDTH-1:0]         ab_xor,
  input  logic [1:0]               op_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH):0]   out_ones,
  output logic [1:0]               out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     op_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [OW-1:0]    ones_mem [DEPTH];
  logic [1:0]       op_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          op_err_q, op_err_d;

  logic [WIDTH-1:0] sel_data;
  logic [OW-1:0]    sel_ones;
  logic             push, pop;

  // Handshake flags depend only on registered occupancy.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sel_data = '0;
    case (op_sel)
      2'b00:   sel_data = ab_and;
      2'b01:   sel_data = ab_or;
      2'b10:   sel_data = ab_xor;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    sel_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel_ones = sel_ones + OW'(sel_data[i]);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    op_err_d = op_err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      op_err_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push && (op_sel == 2'b11)) op_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      op_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      op_err_q <= op_err_d;
    end
  end

  // Storage has no reset; only pointers and occupancy define what is visible.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      data_mem[wr_ptr_q] <= sel_data;
      ones_mem[wr_ptr_q] <= sel_ones;
      op_mem[wr_ptr_q]   <= op_sel;
    end
  end

  assign out_data = out_valid ? data_mem[rd_ptr_q] : '0;
  assign out_ones = out_valid ? ones_mem[rd_ptr_q] : '0;
  assign out_op   = out_valid ? op_mem[rd_ptr_q]   : '0;
  assign count    = count_q;
  assign op_err   = op_err_q;

endmodule

// File: tb/tb_operation_result_buffer.sv
// Scoreboard bench for operation_result_buffer: a queue model tracks every accepted
// entry and each cycle the DUT head, occupancy and flags are compared against it.
module tb_operation_result_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  ones;
    logic [1:0]  op;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ab_and, ab_or, ab_xor;
  logic [1:0]  op_sel;
  logic        in_valid, in_ready, clear, out_valid, out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_ones;
  logic [1:0]  out_op;
  logic [2:0]  count;
  logic        op_err;

  ent_t q[$];
  logic m_err;
  int   checks = 0;
  int   errors = 0;

  operation_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ab_and    (ab_and),
    .ab_or     (ab_or),
    .ab_xor    (ab_xor),
    .op_sel    (op_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ones  (out_ones),
    .out_op    (out_op),
    .count     (count),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t make_ent(input logic [1:0] op, input logic [15:0] a,
                                    input logic [15:0] o, input logic [15:0] x);
    ent_t e;
    case (op)
      2'b00:   e.data = a;
      2'b01:   e.data = o;
      2'b10:   e.data = x;
      default: e.data = 16'h0;
    endcase
    e.ones = 5'($countones(e.data));
    e.op   = op;
    return e;
  endfunction

  task automatic compare_all();
    check("out_valid", out_valid, q.size() != 0);
    check("count", count, q.size());
    check("in_ready", in_ready, q.size() != DEPTH);
    check("op_err", op_err, m_err);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_ones", out_ones, q[0].ones);
      check("out_op", out_op, q[0].op);
    end else begin
      check("idle_data", out_data, 0);
      check("idle_ones", out_ones, 0);
      check("idle_op", out_op, 0);
    end
  endtask

  // Called between edges: applies inputs, advances the model, then checks after the edge.
  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] o, input logic [15:0] x, input logic rdy,
                       input logic clr);
    logic do_push, do_pop;
    ent_t e;
    in_valid  = v;
    op_sel    = op;
    ab_and    = a;
    ab_or     = o;
    ab_xor    = x;
    out_ready = rdy;
    clear     = clr;
    do_push = v && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() > 0);
    e = make_ent(op, a, o, x);
    if (clr) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (do_push && op == 2'b11) m_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, rdy, 1'b0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [15:0] ra, ro, rx;
    rst_n = 1'b0; in_valid = 1'b0; op_sel = 2'b00; clear = 1'b0; out_ready = 1'b0;
    ab_and = '0; ab_or = '0; ab_xor = '0;
    m_err = 1'b0;
    #17;
    compare_all();
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: first edge after reset release accepts an OR result.
    drive(1'b1, 2'b01, 16'h2, 16'h3, 16'h1, 1'b0, 1'b0);
    check("t1_data", out_data, 3);
    check("t1_ones", out_ones, 2);
    check("t1_op", out_op, 1);
    check("t1_count", count, 1);
    idle(1'b1);

    // Test 2: fill, blocked fifth push, drain.
    drive(1'b1, 2'b00, 16'h00F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 16'h00F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 16'h00F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 16'h00F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
    check("t2_full_count", count, 4);
    check("t2_full_ready", in_ready, 0);
    drive(1'b1, 2'b10, 16'h00F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
    check("t2_ignored", count, 4);
    check("t2_h0", out_data, 16'h00F0);
    // Push while full with a pop: pop happens, push is blocked.
    drive(1'b1, 2'b10, 16'h00F0, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0);
    check("t2_h1", out_data, 16'hFFFF);
    check("t2_h1_ones", out_ones, 16);
    idle(1'b1);
    check("t2_h2", out_data, 16'h0F0F);
    check("t2_h2_ones", out_ones, 8);
    idle(1'b1);
    check("t2_h3_ones", out_ones, 4);
    idle(1'b1);
    idle(1'b1);

    // Test 3: steady push+pop at occupancy 2 across pointer wrap.
    drive(1'b1, 2'b00, 16'h0011, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 16'h0022, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'(i % 3), 16'(16'h0100 + i), 16'(16'h0300 + i), 16'(16'h0700 + i),
            1'b1, 1'b0);
      check("t3_count", count, 2);
    end
    idle(1'b1);
    idle(1'b1);

    // Test 4: reserved op, then clear with a simultaneous push.
    drive(1'b1, 2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check("t4_data", out_data, 0);
    check("t4_err", op_err, 1);
    drive(1'b1, 2'b00, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b1);
    check("t4_clr_count", count, 0);
    check("t4_clr_err", op_err, 0);
    idle(1'b0);

    // Test 5: asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b10, 16'h0, 16'h0, 16'(16'h00A0 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_count", count, 0);
    check("t5_ready", in_ready, 1);
    check("t5_data", out_data, 0);
    q.delete();
    m_err = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 16'h5A5A, 16'h0, 16'h0, 1'b0, 1'b0);
    check("t5_head", out_data, 16'h5A5A);
    idle(1'b1);

    // Test 6: random traffic; in_ready must not follow out_ready combinationally.
    for (int c = 0; c < 1000; c++) begin
      out_ready = 1'b0;
      #1;
      check("indep_r0", in_ready, q.size() != DEPTH);
      out_ready = 1'b1;
      #1;
      check("indep_r1", in_ready, q.size() != DEPTH);
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      ro  = 16'($urandom);
      rx  = 16'($urandom);
      drive(1'($urandom_range(0, 1)), rop, ra, ro, rx, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
